// File: rtl/ps2_host_tx_if.sv
// Bus bundle between the PS/2 host transmitter and its surroundings.
// The master side is the command source plus the pin pads; the slave side is the transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2c_i;
    logic       ps2d_i;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       rx_inhibit;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output tx_data, tx_valid, ps2c_i, ps2d_i,
        input  tx_ready, ps2c_oe, ps2d_oe, rx_inhibit, done, err, err_code
    );

    modport slave (
        input  tx_data, tx_valid, ps2c_i, ps2d_i,
        output tx_ready, ps2c_oe, ps2d_oe, rx_inhibit, done, err, err_code
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte on the open-collector PS2C/PS2D pins
// by pulling them low through output enables, and holds the keyboard receiver off meanwhile.
//
// state   | meaning
// IDLE    | bus free, ready for a command byte
// INHIBIT | PS2C held low; start bit asserted in the last cycle
// REQ     | PS2C released, start bit driven, waiting for first device clock fall
// SEND    | data bits and parity shifted out on device falls #2..#10
// ACK     | stop bit released, waiting for fall #11 to sample the device ack
// RELEASE | ack seen, waiting for both lines to return high
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000,
    parameter int FILTER_LEN     = 8
) (
    input  logic         clk_50M,
    input  logic         rst_n,
    ps2_host_tx_if.slave bus
);
    localparam int CNT_SPAN = (START_TIMEOUT > XFER_TIMEOUT)
        ? ((START_TIMEOUT > INHIBIT_CYCLES) ? START_TIMEOUT : INHIBIT_CYCLES)
        : ((XFER_TIMEOUT > INHIBIT_CYCLES) ? XFER_TIMEOUT : INHIBIT_CYCLES);
    localparam int CW = $clog2(CNT_SPAN + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] INH_PRE   = CW'(INHIBIT_CYCLES - 2);
    localparam logic [CW-1:0] START_TC  = CW'(START_TIMEOUT);
    localparam logic [CW-1:0] XFER_TC   = CW'(XFER_TIMEOUT);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_RELEASE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]    bcnt, bcnt_n;
    logic [8:0]    sh, sh_n;
    logic          c_oe, c_oe_n, d_oe, d_oe_n;
    logic          done_q, done_n, err_q, err_n;
    logic [1:0]    code_q, code_n;
    logic          c_s1, c_s2, d_s1, d_s2;
    logic          filt, fall_q;
    logic [FW-1:0] fcnt;
    logic          ready;

    // Synchronizers plus PS2C glitch filter; fall_q pulses on a filtered 1->0 transition.
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            c_s1   <= 1'b1;
            c_s2   <= 1'b1;
            d_s1   <= 1'b1;
            d_s2   <= 1'b1;
            filt   <= 1'b1;
            fcnt   <= '0;
            fall_q <= 1'b0;
        end else begin
            c_s1   <= bus.ps2c_i;
            c_s2   <= c_s1;
            d_s1   <= bus.ps2d_i;
            d_s2   <= d_s1;
            fall_q <= 1'b0;
            if (c_s2 == filt) begin
                fcnt <= '0;
            end else if (fcnt == FILT_LAST) begin
                filt   <= c_s2;
                fcnt   <= '0;
                fall_q <= filt;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            bcnt   <= '0;
            sh     <= '0;
            c_oe   <= 1'b0;
            d_oe   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            code_q <= 2'b00;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            bcnt   <= bcnt_n;
            sh     <= sh_n;
            c_oe   <= c_oe_n;
            d_oe   <= d_oe_n;
            done_q <= done_n;
            err_q  <= err_n;
            code_q <= code_n;
        end
    end

    // The pulse cycle still counts as busy so the source cannot slip a byte in early.
    assign ready   = (state == S_IDLE) && !done_q && !err_q;
    assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt_inc;
        bcnt_n  = bcnt;
        sh_n    = sh;
        c_oe_n  = c_oe;
        d_oe_n  = d_oe;
        done_n  = 1'b0;
        err_n   = 1'b0;
        code_n  = code_q;
        case (state)
            S_IDLE: begin
                cnt_n  = '0;
                c_oe_n = 1'b0;
                d_oe_n = 1'b0;
                if (bus.tx_valid && ready) begin
                    sh_n    = {~^bus.tx_data, bus.tx_data};
                    bcnt_n  = '0;
                    c_oe_n  = 1'b1;
                    state_n = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt == INH_PRE) d_oe_n = 1'b1;
                if (cnt == INH_LAST) begin
                    c_oe_n  = 1'b0;
                    d_oe_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                if (fall_q) begin
                    d_oe_n  = ~sh[0];
                    sh_n    = {1'b0, sh[8:1]};
                    bcnt_n  = 4'd1;
                    cnt_n   = '0;
                    state_n = S_SEND;
                end else if (cnt_inc == START_TC) begin
                    c_oe_n  = 1'b0;
                    d_oe_n  = 1'b0;
                    err_n   = 1'b1;
                    code_n  = 2'b01;
                    state_n = S_IDLE;
                end
            end
            S_SEND, S_ACK, S_RELEASE: begin
                if (cnt_inc == XFER_TC) begin
                    c_oe_n  = 1'b0;
                    d_oe_n  = 1'b0;
                    err_n   = 1'b1;
                    code_n  = 2'b10;
                    state_n = S_IDLE;
                end else if (state == S_SEND) begin
                    if (fall_q) begin
                        bcnt_n = bcnt + 4'd1;
                        if (bcnt == 4'd9) begin
                            d_oe_n  = 1'b0;
                            state_n = S_ACK;
                        end else begin
                            d_oe_n = ~sh[0];
                            sh_n   = {1'b0, sh[8:1]};
                        end
                    end
                end else if (state == S_ACK) begin
                    if (fall_q) begin
                        bcnt_n = 4'd11;
                        if (!d_s2) begin
                            state_n = S_RELEASE;
                        end else begin
                            err_n   = 1'b1;
                            code_n  = 2'b11;
                            state_n = S_IDLE;
                        end
                    end
                end else if (filt && d_s2) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.tx_ready   = ready;
    assign bus.rx_inhibit = (state != S_IDLE);
    assign bus.ps2c_oe    = c_oe;
    assign bus.ps2d_oe    = d_oe;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.err_code   = code_q;
endmodule
